// File: rtl/cpu_mem_pkg.sv
// Shared types and helpers for the CPU data/scratch memory.
// Build option: MEM_PARITY_EN adds one even-parity bit per stored byte.
package cpu_mem_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Even parity: the stored bit makes the byte plus parity hold an even count of ones.
  function automatic logic byte_parity(input logic [BYTE_W-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/mem_clear_fsm.sv
// Sequential post-reset clear sequencer: walks every word address once, then
// releases the RAM. Owns the clear state, address counter and busy flag.
module mem_clear_fsm
  import cpu_mem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  mem_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      if (clr_cnt_q == LAST_ADDR) begin
        state_d   = READY;
        clr_cnt_d = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
      end
    end
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      busy_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      busy_q    <= busy_d;
    end
  end

  // No clear write lands while reset is still held.
  assign clr_we   = (state_q == CLEAR) && !reset;
  assign clr_addr = clr_cnt_q;
  assign busy     = busy_q;

endmodule

// File: rtl/sync_ram_2p.sv
// 1-read/1-write synchronous RAM with byte enables, registered reads and
// selectable read-during-write. Optional per-byte parity via MEM_PARITY_EN.
module sync_ram_2p
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 256,
  parameter int RDW_MODE = 0,
  parameter int ADDR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 rd_valid,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic [DATA_W/8-1:0]  wr_be,
  output logic                 busy,
  output logic                 parity_err,
  input  logic                 par_inject
);

  localparam int              NB        = DATA_W / BYTE_W;
  localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam bit              BYPASS_EN = (RDW_MODE == int'(RDW_NEW));

  logic              busy_w;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  mem_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear (
    .clk      (clk),
    .reset    (reset),
    .busy     (busy_w),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              wr_ok, rd_ok, rd_in;
  logic [ADDR_W-1:0] rd_idx;
  logic              wp_we;
  logic [ADDR_W-1:0] wp_addr;
  logic [DATA_W-1:0] wp_data;
  logic [NB-1:0]     wp_be;
  logic [DATA_W-1:0] old_word, rd_word;
  logic              bypass;

  assign wr_ok  = wr_en && !busy_w && !reset && ({1'b0, wr_addr} < DEPTH_L) && (wr_be != '0);
  assign rd_ok  = rd_en && !busy_w && !reset;
  assign rd_in  = ({1'b0, rd_addr} < DEPTH_L);
  assign rd_idx = rd_in ? rd_addr : '0;
  assign bypass = BYPASS_EN && wr_ok && (wr_addr == rd_addr);

  // Clear sequencer owns the single write port until it releases busy.
  always_comb begin
    if (clr_we) begin
      wp_we   = 1'b1;
      wp_addr = clr_addr;
      wp_data = '0;
      wp_be   = '1;
    end else begin
      wp_we   = wr_ok;
      wp_addr = wr_addr;
      wp_data = wr_data;
      wp_be   = wr_be;
    end
  end

  always_ff @(posedge clk) begin
    if (wp_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wp_be[i]) mem_q[wp_addr][i*BYTE_W +: BYTE_W] <= wp_data[i*BYTE_W +: BYTE_W];
      end
    end
  end

  always_comb begin
    old_word = rd_in ? mem_q[rd_idx] : '0;
    rd_word  = old_word;
    for (int i = 0; i < NB; i++) begin
      if (bypass && wr_be[i]) rd_word[i*BYTE_W +: BYTE_W] = wr_data[i*BYTE_W +: BYTE_W];
    end
  end

`ifdef MEM_PARITY_EN
  logic [NB-1:0] par_q [DEPTH];
  logic [NB-1:0] wr_par, wp_par, rd_par;
  logic          rd_mismatch;

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      wr_par[i] = byte_parity(wr_data[i*BYTE_W +: BYTE_W]) ^ par_inject;
    end
    wp_par = clr_we ? '0 : wr_par;
  end

  always_ff @(posedge clk) begin
    if (wp_we) begin
      for (int i = 0; i < NB; i++) begin
        if (wp_be[i]) par_q[wp_addr][i] <= wp_par[i];
      end
    end
  end

  // Bypassed bytes are checked against the parity that would have been stored.
  always_comb begin
    rd_par      = rd_in ? par_q[rd_idx] : '0;
    rd_mismatch = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (bypass && wr_be[i]) rd_par[i] = wr_par[i];
      if (byte_parity(rd_word[i*BYTE_W +: BYTE_W]) != rd_par[i]) rd_mismatch = 1'b1;
    end
  end
`else
  logic rd_mismatch;
  logic unused_par_inject;
  assign rd_mismatch       = 1'b0;
  assign unused_par_inject = par_inject;
`endif

  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              parity_err_q, parity_err_d;

  always_comb begin
    rd_data_d    = rd_ok ? rd_word : rd_data_q;
    rd_valid_d   = rd_ok;
    parity_err_d = rd_ok && rd_mismatch;
  end

  // Read stage: single registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rd_data_q    <= rd_data_d;
      rd_valid_q   <= rd_valid_d;
      parity_err_q <= parity_err_d;
    end
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign parity_err = parity_err_q;
  assign busy       = busy_w;

endmodule

// File: tb/tb_sync_ram_2p.sv
// Bench for sync_ram_2p: two instances (old-data and bypass read-during-write)
// share stimulus and are checked against a word-array reference model.
module tb_sync_ram_2p;

  localparam int DW    = 32;
  localparam int DEPTH = 200;
  localparam int AW    = 8;
  localparam int NB    = DW / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          rd_en = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic [NB-1:0] wr_be = '0;
  logic          par_inject = 1'b0;

  logic [DW-1:0] rd_data_o, rd_data_n;
  logic          rd_valid_o, rd_valid_n, busy_o, busy_n, perr_o, perr_n;

  sync_ram_2p #(.DATA_W(DW), .DEPTH(DEPTH), .RDW_MODE(0)) dut_old (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o),
    .rd_valid(rd_valid_o), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .busy(busy_o), .parity_err(perr_o), .par_inject(par_inject)
  );

  sync_ram_2p #(.DATA_W(DW), .DEPTH(DEPTH), .RDW_MODE(1)) dut_new (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_valid(rd_valid_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .busy(busy_n), .parity_err(perr_n), .par_inject(par_inject)
  );

  // Reference model: memory contents plus which bytes carry a corrupted parity bit.
  logic [DW-1:0] ref_mem [DEPTH];
  logic [NB-1:0] ref_bad [DEPTH];
  int            clr_left = 0;
  logic [DW-1:0] exp_rd_o = '0, exp_rd_n = '0;
  logic          exp_v = 1'b0, exp_pe_o = 1'b0, exp_pe_n = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".busy_old"},  {31'd0, busy_o},     {31'd0, clr_left > 0});
    chk({tag, ".busy_new"},  {31'd0, busy_n},     {31'd0, clr_left > 0});
    chk({tag, ".valid_old"}, {31'd0, rd_valid_o}, {31'd0, exp_v});
    chk({tag, ".valid_new"}, {31'd0, rd_valid_n}, {31'd0, exp_v});
    chk({tag, ".data_old"},  rd_data_o,           exp_rd_o);
    chk({tag, ".data_new"},  rd_data_n,           exp_rd_n);
    chk({tag, ".perr_old"},  {31'd0, perr_o},     {31'd0, exp_pe_o});
    chk({tag, ".perr_new"},  {31'd0, perr_n},     {31'd0, exp_pe_n});
  endtask

  task automatic step(input string tag, input logic re, input logic [AW-1:0] ra,
                      input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NB-1:0] be, input logic inj);
    logic [DW-1:0] oldw, neww, tmp;
    logic [NB-1:0] oldb, newb, tb;
    rd_en = re; rd_addr = ra; wr_en = we; wr_addr = wa; wr_data = wd; wr_be = be;
    par_inject = inj;
    if (clr_left == 0) begin
      if (re) begin
        oldw = (ra < DEPTH) ? ref_mem[ra] : '0;
        oldb = (ra < DEPTH) ? ref_bad[ra] : '0;
        neww = oldw;
        newb = oldb;
        if (we && (wa < DEPTH) && (wa == ra)) begin
          for (int i = 0; i < NB; i++) begin
            if (be[i]) begin
              neww[i*8 +: 8] = wd[i*8 +: 8];
              newb[i] = inj;
            end
          end
        end
        exp_rd_o = oldw; exp_rd_n = neww; exp_v = 1'b1;
        exp_pe_o = |oldb; exp_pe_n = |newb;
      end else begin
        exp_v = 1'b0; exp_pe_o = 1'b0; exp_pe_n = 1'b0;
      end
      if (we && (wa < DEPTH)) begin
        tmp = ref_mem[wa];
        tb  = ref_bad[wa];
        for (int i = 0; i < NB; i++) begin
          if (be[i]) begin
            tmp[i*8 +: 8] = wd[i*8 +: 8];
            tb[i] = inj;
          end
        end
        ref_mem[wa] = tmp;
        ref_bad[wa] = tb;
      end
    end else begin
      exp_v = 1'b0; exp_pe_o = 1'b0; exp_pe_n = 1'b0;
      clr_left--;
    end
`ifndef MEM_PARITY_EN
    exp_pe_o = 1'b0; exp_pe_n = 1'b0;
`endif
    @(posedge clk); #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  task automatic rnd_step(input string tag);
    logic [AW-1:0] ra, wa;
    ra = ($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, 15));
    wa = ($urandom_range(0, 2) == 0) ? ra :
         (($urandom_range(0, 9) == 0) ? AW'($urandom_range(DEPTH, 255)) : AW'($urandom_range(0, 15)));
    step(tag, 1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa, DW'($urandom),
         NB'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    rd_en = 1'($urandom_range(0, 1)); rd_addr = AW'($urandom_range(0, 15));
    wr_en = 1'($urandom_range(0, 1)); wr_addr = AW'($urandom_range(0, 15));
    wr_data = DW'($urandom); wr_be = '1; par_inject = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    clr_left = DEPTH;
    for (int a = 0; a < DEPTH; a++) begin
      ref_mem[a] = '0;
      ref_bad[a] = '0;
    end
    exp_rd_o = '0; exp_rd_n = '0; exp_v = 1'b0; exp_pe_o = 1'b0; exp_pe_n = 1'b0;
    check_all(tag);
  endtask

  initial begin
    // Power-up clear; busy must fall after exactly DEPTH low-reset cycles.
    do_reset("rst0");
    repeat (DEPTH) idle("clear0");

    step("wr5",  1'b0, 8'd0, 1'b1, 8'd5, 32'hDEADBEEF, 4'hF, 1'b0);
    step("rd5",  1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
    idle("hold5");
    do_reset("rst1");
    repeat (DEPTH) idle("clear1");
    step("rd5_clr", 1'b1, 8'd5, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

    // Byte enables
    step("be_full", 1'b0, 8'd0, 1'b1, 8'd3, 32'h11223344, 4'hF, 1'b0);
    step("be_part", 1'b0, 8'd0, 1'b1, 8'd3, 32'hAABBCCDD, 4'b0101, 1'b0);
    step("be_rd",   1'b1, 8'd3, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
    chk("be_word", rd_data_o, 32'h11BB33DD);
    idle("be_drop");

    // Read-during-write at the same address
    step("rdw",      1'b1, 8'd7, 1'b1, 8'd7, 32'h00000055, 4'hF, 1'b0);
    step("rdw_next", 1'b1, 8'd7, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

    // Out-of-range accesses
    step("oor_wr",  1'b0, 8'd0,   1'b1, 8'd250, 32'h12345678, 4'hF, 1'b0);
    step("oor_rd",  1'b1, 8'd250, 1'b0, 8'd0,   32'h0, 4'h0, 1'b0);
    step("alias50", 1'b1, 8'd50,  1'b0, 8'd0,   32'h0, 4'h0, 1'b0);

    // Parity injection, pulse width, and recovery by rewrite
    step("par_wr",  1'b0, 8'd0, 1'b1, 8'd9, 32'hA5C3_0F17, 4'hF, 1'b1);
    step("par_rd",  1'b1, 8'd9, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);
    idle("par_pulse");
    step("par_fix", 1'b0, 8'd0, 1'b1, 8'd9, 32'hA5C3_0F17, 4'hF, 1'b0);
    step("par_rd2", 1'b1, 8'd9, 1'b0, 8'd0, 32'h0, 4'h0, 1'b0);

    // Reset 100 cycles into a clear, with live requests that must be dropped
    do_reset("rst2");
    repeat (100) rnd_step("clear2");
    do_reset("rst3");
    repeat (DEPTH) rnd_step("clear3");

    repeat (600) rnd_step("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
